// File: rtl/ofm_tile_sequencer.sv
// Walks an output feature map in TILE_DIM x TILE_DIM pixel tiles, channels innermost,
// issuing one beat per (tile, channel) with a per-PE lane mask for edge tiles.
module ofm_tile_sequencer #(
    parameter int TILE_DIM = 4,
    parameter int CNT_W    = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [CNT_W-1:0]             cfg_width,
    input  logic [CNT_W-1:0]             cfg_height,
    input  logic [CNT_W-1:0]             cfg_channels,
    input  logic                         ready,
    output logic                         en,
    output logic [TILE_DIM*TILE_DIM-1:0] valid,
    output logic [CNT_W-1:0]             ch_idx,
    output logic [CNT_W-1:0]             change_row,
    output logic [CNT_W-1:0]             change_channel,
    output logic [CNT_W-1:0]             end_OFM,
    output logic                         busy,
    output logic                         done
);
    localparam int NUM_PE = TILE_DIM * TILE_DIM;
    localparam int SHIFT  = $clog2(TILE_DIM);
    localparam logic [CNT_W:0] STEP  = (CNT_W+1)'(TILE_DIM);
    localparam logic [CNT_W:0] ROUND = (CNT_W+1)'(TILE_DIM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] w_reg, h_reg, ch_reg;
    logic [CNT_W-1:0] col_base_reg, row_base_reg, ch_idx_reg;
    logic [CNT_W-1:0] change_row_reg, change_channel_reg, end_ofm_reg;

    logic             accept, last_ch, col_end, row_end, last_beat, any_zero;
    logic [CNT_W:0]   tiles_w, tiles_h;

    // Boundary math runs one bit wider so 511+3 does not wrap before the shift.
    assign tiles_w   = ({1'b0, w_reg} + ROUND) >> SHIFT;
    assign tiles_h   = ({1'b0, h_reg} + ROUND) >> SHIFT;

    assign accept    = (state_reg == RUN) && ready;
    assign last_ch   = (ch_idx_reg == ch_reg - CNT_W'(1));
    assign col_end   = ({1'b0, col_base_reg} + STEP) >= {1'b0, w_reg};
    assign row_end   = ({1'b0, row_base_reg} + STEP) >= {1'b0, h_reg};
    assign last_beat = accept && last_ch && col_end && row_end;
    assign any_zero  = (w_reg == '0) || (h_reg == '0) || (ch_reg == '0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = any_zero ? DONE : RUN;
            RUN:     if (last_beat) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg          <= IDLE;
            w_reg              <= '0;
            h_reg              <= '0;
            ch_reg             <= '0;
            col_base_reg       <= '0;
            row_base_reg       <= '0;
            ch_idx_reg         <= '0;
            change_row_reg     <= '0;
            change_channel_reg <= '0;
            end_ofm_reg        <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (start) begin
                    w_reg  <= cfg_width;
                    h_reg  <= cfg_height;
                    ch_reg <= cfg_channels;
                end
                LOAD: begin
                    change_row_reg     <= tiles_w[CNT_W-1:0];
                    change_channel_reg <= ch_reg;
                    end_ofm_reg        <= tiles_h[CNT_W-1:0];
                    col_base_reg       <= '0;
                    row_base_reg       <= '0;
                    ch_idx_reg         <= '0;
                end
                RUN: if (accept) begin
                    if (!last_ch) begin
                        ch_idx_reg <= ch_idx_reg + CNT_W'(1);
                    end else begin
                        ch_idx_reg <= '0;
                        if (!col_end) begin
                            col_base_reg <= col_base_reg + CNT_W'(TILE_DIM);
                        end else begin
                            col_base_reg <= '0;
                            row_base_reg <= row_base_reg + CNT_W'(TILE_DIM);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane gi maps to tile pixel (row gi/TILE_DIM, col gi%TILE_DIM).
    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
            localparam logic [CNT_W:0] ROW_OFF = (CNT_W+1)'(gi / TILE_DIM);
            localparam logic [CNT_W:0] COL_OFF = (CNT_W+1)'(gi % TILE_DIM);
            assign valid[gi] = (state_reg == RUN)
                            && (({1'b0, col_base_reg} + COL_OFF) < {1'b0, w_reg})
                            && (({1'b0, row_base_reg} + ROW_OFF) < {1'b0, h_reg});
        end
    endgenerate

    assign en             = (state_reg == RUN);
    assign busy           = (state_reg == LOAD) || (state_reg == RUN);
    assign done           = (state_reg == DONE);
    assign ch_idx         = ch_idx_reg;
    assign change_row     = change_row_reg;
    assign change_channel = change_channel_reg;
    assign end_OFM        = end_ofm_reg;
endmodule

// File: tb/tb_ofm_tile_sequencer.sv
// Scoreboard bench: a tile-walk model queues expected beats, a monitor pops on each accepted beat.
module tb_ofm_tile_sequencer;
    logic        clk = 1'b0;
    logic        reset, start, ready;
    logic [8:0]  cfg_width, cfg_height, cfg_channels;
    logic        en, busy, done;
    logic [15:0] valid;
    logic [8:0]  ch_idx, change_row, change_channel, end_OFM;

    ofm_tile_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_channels(cfg_channels),
        .ready(ready), .en(en), .valid(valid), .ch_idx(ch_idx),
        .change_row(change_row), .change_channel(change_channel), .end_OFM(end_OFM),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] mask;
        logic [8:0]  ch;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          first_en_cyc = -1;
    int          done_cyc = -1;
    bit          hold_prev = 1'b0;
    logic [15:0] prev_valid;
    logic [8:0]  prev_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: ceil-divide the map into 4x4 tiles, rows outer, columns, channels inner.
    task automatic model_push(input int w, input int h, input int c);
        for (int ty = 0; ty < (h + 3) / 4; ty++)
            for (int tx = 0; tx < (w + 3) / 4; tx++)
                for (int k = 0; k < c; k++) begin
                    beat_t b;
                    b.mask = '0;
                    for (int r = 0; r < 4; r++)
                        for (int cc = 0; cc < 4; cc++)
                            if (tx * 4 + cc < w && ty * 4 + r < h) b.mask[r * 4 + cc] = 1'b1;
                    b.ch = 9'(k);
                    exp_q.push_back(b);
                end
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_hold_en", en, 1);
                    check("stall_hold_valid", valid, prev_valid);
                    check("stall_hold_ch_idx", ch_idx, prev_ch);
                end
                if (en) begin
                    if (first_en_cyc < 0) first_en_cyc = cyc;
                    check("valid_nonzero", valid != 16'h0, 1);
                end
                if (en && ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_beat: got valid=%0h ch_idx=%0d expected no beat", valid, ch_idx);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_valid", valid, e.mask);
                        check("beat_ch_idx", ch_idx, e.ch);
                    end
                end
                hold_prev  = en && !ready;
                prev_valid = valid;
                prev_ch    = ch_idx;
                if (done) begin
                    done_cyc = cyc;
                    check("done_en_low", en, 0);
                    check("done_busy_low", busy, 0);
                    check("done_all_beats", exp_q.size(), 0);
                end
            end
        end
    end

    // mode 0: ready=1; 1: random ready; 2: ready low for relative cycles 3..5.
    task automatic run_map(input int w, input int h, input int c, input int mode,
                           input bit disturb, input int exp_done_lat);
        int t, rel;
        model_push(w, h, c);
        first_en_cyc = -1;
        done_cyc     = -1;
        cfg_width    = 9'(w);
        cfg_height   = 9'(h);
        cfg_channels = 9'(c);
        start        = 1'b1;
        t            = cyc;
        ready        = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            rel   = cyc - t;
            if (disturb) begin
                cfg_width    = 9'($urandom);
                cfg_height   = 9'($urandom);
                cfg_channels = 9'($urandom);
                if (rel == 3) start = 1'b1;
            end
            case (mode)
                1:       ready = ($urandom_range(0, 3) != 0);
                2:       ready = !(rel >= 3 && rel <= 5);
                default: ready = 1'b1;
            endcase
        end
        start = 1'b0;
        ready = 1'b1;
        if (done_cyc < 0) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done for w=%0d h=%0d c=%0d", w, h, c);
            exp_q.delete();
        end else begin
            if (exp_done_lat >= 0) check("done_latency", done_cyc - t, exp_done_lat);
            if (w != 0 && h != 0 && c != 0) check("first_en_latency", first_en_cyc - t, 2);
            else check("no_en_when_empty", first_en_cyc, -1);
            check("change_row", change_row, 9'((w + 3) >> 2));
            check("change_channel", change_channel, 9'(c));
            check("end_OFM", end_OFM, 9'((h + 3) >> 2));
        end
        $display("[TB] map w=%0d h=%0d ch=%0d mode=%0d disturb=%0d done_at=+%0d",
                 w, h, c, mode, disturb, done_cyc - t);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"}, en, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_ch_idx"}, ch_idx, 0);
        check({tag, "_change_row"}, change_row, 0);
        check({tag, "_change_channel"}, change_channel, 0);
        check({tag, "_end_OFM"}, end_OFM, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin : stimulus
        int t;
        reset        = 1'b1;
        start        = 1'b0;
        ready        = 1'b1;
        cfg_width    = '0;
        cfg_height   = '0;
        cfg_channels = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_map(8, 8, 2, 0, 1'b0, 10);
        run_map(6, 5, 1, 0, 1'b0, -1);
        run_map(8, 4, 3, 0, 1'b0, 8);
        run_map(8, 4, 3, 2, 1'b0, 11);
        run_map(8, 8, 0, 0, 1'b0, 2);
        run_map(0, 5, 2, 0, 1'b0, 2);
        run_map(8, 8, 2, 0, 1'b1, 10);
        run_map(13, 7, 3, 1, 1'b1, -1);
        run_map(511, 4, 1, 0, 1'b0, -1);

        // Abort mid-run on beat 3.
        model_push(8, 8, 2);
        first_en_cyc = -1;
        done_cyc     = -1;
        cfg_width    = 9'd8;
        cfg_height   = 9'd8;
        cfg_channels = 9'd2;
        start        = 1'b1;
        t            = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (cyc - t < 4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_outputs("abort");
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cyc, -1);
        $display("[TB] abort at beat 3 checked");
        run_map(8, 8, 2, 0, 1'b0, 10);

        for (int n = 0; n < 10; n++)
            run_map($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 4),
                    1, 1'(n % 2), -1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
